// File: rtl/z480_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : z480_pkg                                               |
// | Brief   : Shared Z480 P7 types: renamed uop and reorder-buffer    |
// |           entry/index definitions.                               |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package z480_pkg;

  // Default reorder-buffer geometry.
  localparam int Z480_ROB_DEPTH = 64;

  typedef logic [5:0] z480_rob_idx_t;

  // Renamed uop as handed from rename/dispatch to the back end.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [6:0]  prd;
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  prd_old;
    logic        rd_wen;
  } z480_uop_rn_t;

  // One reorder-buffer slot.
  typedef struct packed {
    logic         valid;
    logic         done;
    logic         has_trap;
    logic [31:0]  trap_cause;
    z480_uop_rn_t uop;
  } z480_rob_entry_t;

endpackage : z480_pkg
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rob                                                    |
// | Brief   : Z480 P7 reorder buffer. Circular in-order queue that   |
// |           allocates at the tail, records writeback by index and  |
// |           retires from the head.                                 |
// |           Optional: Z480_ROB_STATS_EN adds stall_full_cycles and |
// |           max_count statistics outputs.                          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module rob
  import z480_pkg::*;
#(
  parameter int DEPTH = Z480_ROB_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  z480_uop_rn_t       alloc_uop,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic               wb_valid,
  input  logic [IDX_W-1:0]   wb_idx,
  input  logic               wb_has_trap,
  input  logic [31:0]        wb_trap_cause,
  output logic               head_valid,
  output logic               head_done,
  output z480_uop_rn_t       head_uop,
  output logic [IDX_W-1:0]   head_idx,
  output logic               head_has_trap,
  output logic [31:0]        head_trap_cause,
  input  logic               head_pop,
  output logic [IDX_W:0]     count,
`ifdef Z480_ROB_STATS_EN
  output logic [63:0]        stall_full_cycles,
  output logic [IDX_W:0]     max_count,
`endif
  output logic               empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [IDX_W:0] c_ptr_one = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0]   head_q;
  logic [IDX_W:0]   tail_q;
  logic [IDX_W-1:0] head_lo;
  logic [IDX_W-1:0] tail_lo;
  logic             full;
  logic             alloc_fire;
  logic             pop_fire;
  logic             wb_fire;

  z480_rob_entry_t  entries [DEPTH];
  z480_rob_entry_t  head_ent;

  assign head_lo  = head_q[IDX_W-1:0];
  assign tail_lo  = tail_q[IDX_W-1:0];
  assign head_ent = entries[head_lo];

  // Occupancy and handshake qualification, all from registered state only.
  always_comb begin
    full        = (head_q[IDX_W] != tail_q[IDX_W]) && (head_lo == tail_lo);
    count       = tail_q - head_q;
    empty       = (count == '0);
    alloc_ready = !full;
    alloc_idx   = tail_lo;
    alloc_fire  = alloc_valid && alloc_ready && !flush;
    pop_fire    = head_pop && head_ent.valid && !flush;
    // A writeback aimed at the entry leaving this cycle would resurrect
    // stale state, so it is dropped.
    wb_fire     = wb_valid && entries[wb_idx].valid && !flush &&
                  !(pop_fire && (wb_idx == head_lo));
  end

  // Head view for commit; fields are masked while the head slot is free.
  always_comb begin
    head_idx        = head_lo;
    head_valid      = head_ent.valid;
    head_done       = head_ent.valid && head_ent.done;
    head_has_trap   = head_ent.valid && head_ent.has_trap;
    head_trap_cause = head_ent.valid ? head_ent.trap_cause : 32'd0;
    head_uop        = head_ent.valid ? head_ent.uop : '0;
  end

  // Pointer update: flush returns both pointers to zero, otherwise advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + c_ptr_one;
      if (pop_fire)   head_q <= head_q + c_ptr_one;
    end
  end

  // Entry storage: allocate at tail, complete by index, free at head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      // Allocation only targets a free slot, so it never overlaps the
      // writeback or pop of a live entry.
      if (alloc_fire) begin
        entries[tail_lo].valid      <= 1'b1;
        entries[tail_lo].done       <= 1'b0;
        entries[tail_lo].has_trap   <= 1'b0;
        entries[tail_lo].trap_cause <= 32'd0;
        entries[tail_lo].uop        <= alloc_uop;
      end
      if (wb_fire) begin
        entries[wb_idx].done       <= 1'b1;
        entries[wb_idx].has_trap   <= wb_has_trap;
        entries[wb_idx].trap_cause <= wb_trap_cause;
      end
      if (pop_fire) begin
        entries[head_lo].valid <= 1'b0;
        entries[head_lo].done  <= 1'b0;
      end
    end
  end

`ifdef Z480_ROB_STATS_EN
  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_full_cycles <= 64'd0;
      max_count         <= '0;
    end else begin
      if (alloc_valid && !alloc_ready) begin
        stall_full_cycles <= stall_full_cycles + 64'd1;
      end
      if (count > max_count) begin
        max_count <= count;
      end
    end
  end
`endif

endmodule : rob
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_rob                                                 |
// | Brief   : Self-checking bench for rob: table of single-cycle     |
// |           vectors plus hand sequences for fill/wrap, flush and   |
// |           asynchronous reset.                                    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_rob;
  import z480_pkg::*;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         alloc_valid;
  logic         alloc_ready;
  z480_uop_rn_t alloc_uop;
  logic [5:0]   alloc_idx;
  logic         wb_valid;
  logic [5:0]   wb_idx;
  logic         wb_has_trap;
  logic [31:0]  wb_trap_cause;
  logic         head_valid;
  logic         head_done;
  z480_uop_rn_t head_uop;
  logic [5:0]   head_idx;
  logic         head_has_trap;
  logic [31:0]  head_trap_cause;
  logic         head_pop;
  logic [6:0]   count;
  logic         empty;
`ifdef Z480_ROB_STATS_EN
  logic [63:0]  stall_full_cycles;
  logic [6:0]   max_count;
`endif

  int errors = 0;
  int checks = 0;

  rob #(.DEPTH(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .alloc_valid     (alloc_valid),
    .alloc_ready     (alloc_ready),
    .alloc_uop       (alloc_uop),
    .alloc_idx       (alloc_idx),
    .wb_valid        (wb_valid),
    .wb_idx          (wb_idx),
    .wb_has_trap     (wb_has_trap),
    .wb_trap_cause   (wb_trap_cause),
    .head_valid      (head_valid),
    .head_done       (head_done),
    .head_uop        (head_uop),
    .head_idx        (head_idx),
    .head_has_trap   (head_has_trap),
    .head_trap_cause (head_trap_cause),
    .head_pop        (head_pop),
    .count           (count),
`ifdef Z480_ROB_STATS_EN
    .stall_full_cycles (stall_full_cycles),
    .max_count       (max_count),
`endif
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [31:0] pc;
    logic        wv;
    logic [5:0]  wi;
    logic        wt;
    logic [31:0] wc;
    logic        pop;
    logic [6:0]  e_count;
    logic [5:0]  e_aidx;
    logic        e_hv;
    logic        e_hd;
    logic [5:0]  e_hidx;
    logic [31:0] e_pc;
    logic        e_ht;
    logic [31:0] e_hc;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic av, logic [31:0] pc, logic wv, logic [5:0] wi,
                              logic wt, logic [31:0] wc, logic pop,
                              logic [6:0] c, logic [5:0] ai, logic hv, logic hd,
                              logic [5:0] hi, logic [31:0] hpc, logic ht, logic [31:0] hc);
    vec_t v;
    v.av = av; v.pc = pc; v.wv = wv; v.wi = wi; v.wt = wt; v.wc = wc; v.pop = pop;
    v.e_count = c; v.e_aidx = ai; v.e_hv = hv; v.e_hd = hd; v.e_hidx = hi;
    v.e_pc = hpc; v.e_ht = ht; v.e_hc = hc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_uop = '0;
    wb_valid = 1'b0; wb_idx = '0; wb_has_trap = 1'b0; wb_trap_cause = '0;
    head_pop = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " count"},       64'(count), 64'd0);
    chk({tag, " empty"},       64'(empty), 64'd1);
    chk({tag, " alloc_ready"}, 64'(alloc_ready), 64'd1);
    chk({tag, " alloc_idx"},   64'(alloc_idx), 64'd0);
    chk({tag, " head_valid"},  64'(head_valid), 64'd0);
    chk({tag, " head_done"},   64'(head_done), 64'd0);
    chk({tag, " head_idx"},    64'(head_idx), 64'd0);
    chk({tag, " head_trap"},   64'(head_has_trap), 64'd0);
    chk({tag, " head_cause"},  64'(head_trap_cause), 64'd0);
    chk({tag, " head_uop"},    64'(head_uop.pc), 64'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;

    // Post-edge expectations for each single-cycle vector.
    //            av pc         wv wi wt wc     pop  cnt aidx hv hd hidx pc         ht hc
    vecs[0]  = mk(1, 32'h100, 0, 0, 0, 32'h0, 0,   1,  1,  1, 0, 0, 32'h100, 0, 32'h0);
    vecs[1]  = mk(1, 32'h104, 0, 0, 0, 32'h0, 0,   2,  2,  1, 0, 0, 32'h100, 0, 32'h0);
    vecs[2]  = mk(1, 32'h108, 0, 0, 0, 32'h0, 0,   3,  3,  1, 0, 0, 32'h100, 0, 32'h0);
    vecs[3]  = mk(0, 32'h0,   1, 1, 0, 32'h0, 0,   3,  3,  1, 0, 0, 32'h100, 0, 32'h0);
    vecs[4]  = mk(0, 32'h0,   1, 0, 0, 32'h0, 0,   3,  3,  1, 1, 0, 32'h100, 0, 32'h0);
    vecs[5]  = mk(0, 32'h0,   0, 0, 0, 32'h0, 1,   2,  3,  1, 1, 1, 32'h104, 0, 32'h0);
    vecs[6]  = mk(0, 32'h0,   0, 0, 0, 32'h0, 1,   1,  3,  1, 0, 2, 32'h108, 0, 32'h0);
    vecs[7]  = mk(0, 32'h0,   1, 0, 1, 32'h7, 0,   1,  3,  1, 0, 2, 32'h108, 0, 32'h0);
    vecs[8]  = mk(0, 32'h0,   1, 2, 1, 32'hD, 0,   1,  3,  1, 1, 2, 32'h108, 1, 32'hD);
    vecs[9]  = mk(0, 32'h0,   1, 2, 1, 32'h5, 0,   1,  3,  1, 1, 2, 32'h108, 1, 32'h5);
    vecs[10] = mk(0, 32'h0,   1, 2, 0, 32'h0, 0,   1,  3,  1, 1, 2, 32'h108, 0, 32'h0);
    vecs[11] = mk(1, 32'h10C, 0, 0, 0, 32'h0, 1,   1,  4,  1, 0, 3, 32'h10C, 0, 32'h0);
    vecs[12] = mk(1, 32'h110, 1, 3, 1, 32'h9, 1,   1,  5,  1, 0, 4, 32'h110, 0, 32'h0);
    vecs[13] = mk(0, 32'h0,   1, 4, 1, 32'h9, 1,   0,  5,  0, 0, 5, 32'h0,   0, 32'h0);
    vecs[14] = mk(0, 32'h0,   0, 0, 0, 32'h0, 1,   0,  5,  0, 0, 5, 32'h0,   0, 32'h0);
    vecs[15] = mk(1, 32'h114, 0, 0, 0, 32'h0, 0,   1,  6,  1, 0, 5, 32'h114, 0, 32'h0);

    // Reset state while rst is held.
    step();
    step();
    chk_reset_state("reset");
    rst = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NVEC; i++) begin
      alloc_valid   = vecs[i].av;
      alloc_uop     = '0;
      alloc_uop.pc  = vecs[i].pc;
      wb_valid      = vecs[i].wv;
      wb_idx        = vecs[i].wi;
      wb_has_trap   = vecs[i].wt;
      wb_trap_cause = vecs[i].wc;
      head_pop      = vecs[i].pop;
      step();
      idle_inputs();
      chk($sformatf("v%0d count", i),      64'(count), 64'(vecs[i].e_count));
      chk($sformatf("v%0d empty", i),      64'(empty), 64'(vecs[i].e_count == 7'd0));
      chk($sformatf("v%0d alloc_idx", i),  64'(alloc_idx), 64'(vecs[i].e_aidx));
      chk($sformatf("v%0d head_valid", i), 64'(head_valid), 64'(vecs[i].e_hv));
      chk($sformatf("v%0d head_done", i),  64'(head_done), 64'(vecs[i].e_hd));
      chk($sformatf("v%0d head_idx", i),   64'(head_idx), 64'(vecs[i].e_hidx));
      chk($sformatf("v%0d head_trap", i),  64'(head_has_trap), 64'(vecs[i].e_ht));
      chk($sformatf("v%0d head_cause", i), 64'(head_trap_cause), 64'(vecs[i].e_hc));
      if (vecs[i].e_hv) begin
        chk($sformatf("v%0d head_pc", i), 64'(head_uop.pc), 64'(vecs[i].e_pc));
      end
    end

    // Fill to capacity from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      alloc_valid  = 1'b1;
      alloc_uop    = '0;
      alloc_uop.pc = 32'h1000 + 32'(4 * i);
      chk($sformatf("fill%0d alloc_idx", i), 64'(alloc_idx), 64'(i));
      if (i == 63) chk("fill63 ready", 64'(alloc_ready), 64'd1);
      step();
    end
    idle_inputs();
    chk("full count", 64'(count), 64'd64);
    chk("full ready", 64'(alloc_ready), 64'd0);
    chk("full empty", 64'(empty), 64'd0);

    // Trap writeback to the head at full occupancy.
    wb_valid = 1'b1; wb_idx = 6'd0; wb_has_trap = 1'b1; wb_trap_cause = 32'hD;
    step();
    idle_inputs();
    chk("trap head_done",  64'(head_done), 64'd1);
    chk("trap head_trap",  64'(head_has_trap), 64'd1);
    chk("trap head_cause", 64'(head_trap_cause), 64'hD);

    // Alloc and pop together while full: pop only.
    alloc_valid = 1'b1; alloc_uop = '0; alloc_uop.pc = 32'h2000; head_pop = 1'b1;
    step();
    idle_inputs();
    chk("fullpop count",     64'(count), 64'd63);
    chk("fullpop alloc_idx", 64'(alloc_idx), 64'd0);
    chk("fullpop head_idx",  64'(head_idx), 64'd1);
    chk("fullpop head_pc",   64'(head_uop.pc), 64'h1004);
    chk("fullpop ready",     64'(alloc_ready), 64'd1);

    // Next allocation lands on index 0 after the wrap.
    alloc_valid = 1'b1; alloc_uop = '0; alloc_uop.pc = 32'h2000;
    chk("wrap alloc_idx pre", 64'(alloc_idx), 64'd0);
    step();
    idle_inputs();
    chk("wrap count",     64'(count), 64'd64);
    chk("wrap ready",     64'(alloc_ready), 64'd0);
    chk("wrap alloc_idx", 64'(alloc_idx), 64'd1);

    // Complete the head, then flush with every other request active.
    wb_valid = 1'b1; wb_idx = 6'd1;
    step();
    idle_inputs();
    chk("prefl head_done", 64'(head_done), 64'd1);
    flush = 1'b1; alloc_valid = 1'b1; alloc_uop.pc = 32'h2222;
    wb_valid = 1'b1; wb_idx = 6'd2; head_pop = 1'b1;
    step();
    idle_inputs();
    chk("flush count",      64'(count), 64'd0);
    chk("flush empty",      64'(empty), 64'd1);
    chk("flush alloc_idx",  64'(alloc_idx), 64'd0);
    chk("flush head_idx",   64'(head_idx), 64'd0);
    chk("flush head_valid", 64'(head_valid), 64'd0);
    chk("flush ready",      64'(alloc_ready), 64'd1);

    // Re-allocate over previously completed slots: no stale done bits.
    for (int i = 0; i < 2; i++) begin
      alloc_valid = 1'b1; alloc_uop = '0; alloc_uop.pc = 32'h3000 + 32'(4 * i);
      step();
    end
    idle_inputs();
    chk("realloc count",     64'(count), 64'd2);
    chk("realloc head_done", 64'(head_done), 64'd0);
    chk("realloc head_pc",   64'(head_uop.pc), 64'h3000);
    head_pop = 1'b1;
    step();
    idle_inputs();
    chk("realloc1 head_idx",  64'(head_idx), 64'd1);
    chk("realloc1 head_done", 64'(head_done), 64'd0);
    chk("realloc1 head_pc",   64'(head_uop.pc), 64'h3004);

    // Grow to 10 entries, then assert reset between clock edges.
    for (int i = 0; i < 9; i++) begin
      alloc_valid = 1'b1; alloc_uop = '0; alloc_uop.pc = 32'h4000 + 32'(4 * i);
      step();
    end
    idle_inputs();
    chk("prerst count", 64'(count), 64'd10);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("async");
    step();
    rst = 1'b0;

    // Operation resumes cleanly after reset.
    alloc_valid = 1'b1; alloc_uop = '0; alloc_uop.pc = 32'h5000;
    chk("post alloc_idx pre", 64'(alloc_idx), 64'd0);
    step();
    idle_inputs();
    chk("post count",   64'(count), 64'd1);
    chk("post head_pc", 64'(head_uop.pc), 64'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rob
`default_nettype wire
